// File: rtl/inspike_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inspike_seq_ctrl_pkg
// Shared definitions for the input-spike sequencer:
//   - seq_state_e : sequencer state encoding (3 bits, IDLE..DONE)
//   - DEF_AXON_CNT_BIT_WIDTH / DEF_NUM_AXONS : default sizing of the axon sweep
// -----------------------------------------------------------------------------
package inspike_seq_ctrl_pkg;

   localparam int DEF_AXON_CNT_BIT_WIDTH = 8;
   localparam int DEF_NUM_AXONS          = 256;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RCL  = 3'd2,
      ST_SAVE = 3'd3,
      ST_LRN  = 3'd4,
      ST_DONE = 3'd5
   } seq_state_e;

endpackage

// File: rtl/inspike_seq_ctrl_axon_sweep_cnt.sv
// -----------------------------------------------------------------------------
// inspike_seq_ctrl_axon_sweep_cnt
// Axon address counter shared by the recall and learn sweeps.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (counter -> 0)
//   clr_i  : synchronous clear (counter -> 0)
//   en_i   : advance by one; from NUM_AXONS-1 it returns to 0
//   cnt_o  : current count
//   tc_o   : terminal count (cnt_o == NUM_AXONS-1)
// -----------------------------------------------------------------------------
module inspike_seq_ctrl_axon_sweep_cnt
   import inspike_seq_ctrl_pkg::*;
#(
   parameter int NUM_AXONS          = DEF_NUM_AXONS,
   parameter int AXON_CNT_BIT_WIDTH = DEF_AXON_CNT_BIT_WIDTH
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clr_i,
   input  logic                          en_i,
   output logic [AXON_CNT_BIT_WIDTH-1:0] cnt_o,
   output logic                          tc_o
);

   localparam logic [AXON_CNT_BIT_WIDTH-1:0] LP_LAST = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

   logic [AXON_CNT_BIT_WIDTH-1:0] r_cnt;

   // Explicit compare against the last axon: the counter never relies on
   // natural overflow, so NUM_AXONS need not be a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign cnt_o = r_cnt;
   assign tc_o  = (r_cnt == LP_LAST);

endmodule

// File: rtl/inspike_seq_ctrl.sv
// -----------------------------------------------------------------------------
// inspike_seq_ctrl
// Per-timestep sequencer for a neuron core's input spike buffer. A tick loads
// the buffer, sweeps all axons for recall reads, optionally snapshots recall
// spikes into the learn buffer and sweeps learn reads, then pulses done.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   tick_i                : timestep start pulse (ignored and flagged if busy)
//   lrn_en_i              : learning enable, sampled when a tick is accepted
//   rdy_i                 : downstream ready, gates every read issue
//   start_o               : buffer load strobe
//   RclAxonAddr_o         : recall read address
//   rdEn_RclInSpike_o     : recall read enable
//   saveRclSpikes_o       : recall->learn snapshot strobe
//   LrnAxonAddr_o         : learn read address
//   rdEn_LrnInSpike_o     : learn read enable
//   rcl_vld_o/axon/last   : recall issue delayed one cycle (aligned with data)
//   lrn_vld_o/lrn_axon_o  : learn issue delayed one cycle
//   busy_o                : not IDLE
//   done_o                : end-of-timestep pulse
//   overrun_o             : sticky, tick arrived while busy
// -----------------------------------------------------------------------------
module inspike_seq_ctrl
   import inspike_seq_ctrl_pkg::*;
#(
   parameter int NUM_AXONS          = DEF_NUM_AXONS,
   parameter int AXON_CNT_BIT_WIDTH = DEF_AXON_CNT_BIT_WIDTH
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          tick_i,
   input  logic                          lrn_en_i,
   input  logic                          rdy_i,
   output logic                          start_o,
   output logic [AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_o,
   output logic                          rdEn_RclInSpike_o,
   output logic                          saveRclSpikes_o,
   output logic [AXON_CNT_BIT_WIDTH-1:0] LrnAxonAddr_o,
   output logic                          rdEn_LrnInSpike_o,
   output logic                          rcl_vld_o,
   output logic [AXON_CNT_BIT_WIDTH-1:0] rcl_axon_o,
   output logic                          rcl_last_o,
   output logic                          lrn_vld_o,
   output logic [AXON_CNT_BIT_WIDTH-1:0] lrn_axon_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          overrun_o
);

   seq_state_e                    r_state;
   logic                          r_lrn_q;
   logic                          r_last_iss;   // current read strobe is the final axon
   logic                          r_start, r_save, r_done, r_busy, r_overrun;
   logic                          r_rd_rcl, r_rd_lrn;
   logic [AXON_CNT_BIT_WIDTH-1:0] r_rcl_addr, r_lrn_addr;
   logic                          r_rcl_vld, r_rcl_last, r_lrn_vld;
   logic [AXON_CNT_BIT_WIDTH-1:0] r_rcl_axon, r_lrn_axon;

   logic [AXON_CNT_BIT_WIDTH-1:0] w_cnt;
   logic                          w_tc;
   logic                          w_cnt_en, w_cnt_clr;
   logic                          w_rcl_end, w_lrn_end;

   // A phase ends once its final read is on the outputs. Read issues are
   // decided one cycle ahead, so LOAD and SAVE already decide the first
   // read of the phase that follows them.
   assign w_rcl_end = (r_state == ST_RCL) && r_rd_rcl && r_last_iss;
   assign w_lrn_end = (r_state == ST_LRN) && r_rd_lrn && r_last_iss;
   assign w_cnt_en  = rdy_i && ((r_state == ST_LOAD) || (r_state == ST_SAVE) ||
                                ((r_state == ST_RCL) && !w_rcl_end) ||
                                ((r_state == ST_LRN) && !w_lrn_end));
   assign w_cnt_clr = (r_state == ST_IDLE) && tick_i;

   inspike_seq_ctrl_axon_sweep_cnt #(
      .NUM_AXONS          (NUM_AXONS),
      .AXON_CNT_BIT_WIDTH (AXON_CNT_BIT_WIDTH)
   ) u_sweep_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (w_cnt_clr),
      .en_i  (w_cnt_en),
      .cnt_o (w_cnt),
      .tc_o  (w_tc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_lrn_q    <= 1'b0;
         r_last_iss <= 1'b0;
         r_start    <= 1'b0;
         r_save     <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
         r_rd_rcl   <= 1'b0;
         r_rd_lrn   <= 1'b0;
         r_rcl_addr <= '0;
         r_lrn_addr <= '0;
         r_rcl_vld  <= 1'b0;
         r_rcl_axon <= '0;
         r_rcl_last <= 1'b0;
         r_lrn_vld  <= 1'b0;
         r_lrn_axon <= '0;
      end else begin
         r_start    <= 1'b0;
         r_save     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_rcl   <= 1'b0;
         r_rd_lrn   <= 1'b0;
         r_last_iss <= w_cnt_en && w_tc;

         // Alignment pipeline: runs independently of the state so the final
         // valid still appears after the FSM has moved on.
         r_rcl_vld  <= r_rd_rcl;
         r_rcl_axon <= r_rcl_addr;
         r_rcl_last <= r_rd_rcl && r_last_iss;
         r_lrn_vld  <= r_rd_lrn;
         r_lrn_axon <= r_lrn_addr;

         // DONE still counts as busy, so a tick coinciding with done_o is flagged.
         if (tick_i && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (tick_i) begin
                  r_state <= ST_LOAD;
                  r_lrn_q <= lrn_en_i;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_LOAD, ST_RCL: begin
               if (w_rcl_end) begin
                  if (r_lrn_q) begin
                     r_state <= ST_SAVE;
                     r_save  <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_state    <= ST_RCL;
                  r_rd_rcl   <= rdy_i;
                  r_rcl_addr <= w_cnt;
               end
            end
            ST_SAVE, ST_LRN: begin
               if (w_lrn_end) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= ST_LRN;
                  r_rd_lrn   <= rdy_i;
                  r_lrn_addr <= w_cnt;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign start_o           = r_start;
   assign RclAxonAddr_o     = r_rcl_addr;
   assign rdEn_RclInSpike_o = r_rd_rcl;
   assign saveRclSpikes_o   = r_save;
   assign LrnAxonAddr_o     = r_lrn_addr;
   assign rdEn_LrnInSpike_o = r_rd_lrn;
   assign rcl_vld_o         = r_rcl_vld;
   assign rcl_axon_o        = r_rcl_axon;
   assign rcl_last_o        = r_rcl_last;
   assign lrn_vld_o         = r_lrn_vld;
   assign lrn_axon_o        = r_lrn_axon;
   assign busy_o            = r_busy;
   assign done_o            = r_done;
   assign overrun_o         = r_overrun;

endmodule

// File: doc/inspike_seq_ctrl.md
Name: inspike_seq_ctrl

Overview:
- Per-timestep sequencer for the input spike buffer of one neuron core.
- On each timestep tick it loads the buffer, then sweeps every axon address for the recall read stream.
- Optionally it snapshots recall spikes into the learn buffer and sweeps the learn read stream.
- It also produces valid/index strobes aligned with the buffer's registered read data.

Parameters:
- NUM_AXONS, 256, number of axons swept per phase; must be ≤ 2^AXON_CNT_BIT_WIDTH and ≥ 2.
- AXON_CNT_BIT_WIDTH, 8, width of axon address/counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- tick_i  in  1  timestep start pulse.
- lrn_en_i  in  1  learning enable; sampled only when tick_i is accepted.
- rdy_i  in  1  downstream ready; gates every read issue.
- start_o  out  1  buffer load strobe (one cycle).
- RclAxonAddr_o  out  AXON_CNT_BIT_WIDTH  recall read address.
- rdEn_RclInSpike_o  out  1  recall read enable.
- saveRclSpikes_o  out  1  recall→learn snapshot strobe (one cycle).
- LrnAxonAddr_o  out  AXON_CNT_BIT_WIDTH  learn read address.
- rdEn_LrnInSpike_o  out  1  learn read enable.
- rcl_vld_o  out  1  rdEn_RclInSpike_o delayed one cycle; aligned with the buffer's recall data.
- rcl_axon_o  out  AXON_CNT_BIT_WIDTH  address delayed one cycle, aligned with rcl_vld_o.
- rcl_last_o  out  1  high with rcl_vld_o for axon NUM_AXONS-1.
- lrn_vld_o  out  1  learn equivalent of rcl_vld_o.
- lrn_axon_o  out  AXON_CNT_BIT_WIDTH  learn equivalent of rcl_axon_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of timestep.
- overrun_o  out  1  sticky: tick_i arrived while busy.

Behaviour:
- All outputs are registered. Reset (rst_i=1 at a clock edge) forces state IDLE and clears the counter and every output to 0, including sticky overrun_o.
- Reset mid-sweep aborts the sweep with no further strobes. overrun_o is cleared only by reset.
- States: IDLE, LOAD, RCL, SAVE, LRN, DONE.
- IDLE:
  - tick_i=1 → LOAD; latch lrn_en_i into lrn_q; counter←0.
- LOAD:
  - start_o=1 for exactly this one cycle → RCL.
- RCL:
  - rdEn_RclInSpike_o = rdy_i (combinationally qualified, then registered, so the issue lands one cycle after rdy_i is seen). RclAxonAddr_o = counter.
  - Counter increments only on an issued read.
  - On the issue with counter = NUM_AXONS-1: counter←0, then → SAVE if lrn_q, else → DONE.
  - rdy_i=0 holds address and counter; no read is issued.
- SAVE:
  - saveRclSpikes_o=1 for one cycle → LRN.
- LRN:
  - Identical to RCL using rdEn_LrnInSpike_o / LrnAxonAddr_o; the final issue → DONE.
- DONE:
  - done_o=1 for one cycle → IDLE.
- Latency, with rdy_i held high:
  - tick accepted at cycle T → start_o at T+1.
  - First recall issue at T+2; last recall issue at T+1+NUM_AXONS.
  - The learn phase adds 1+NUM_AXONS cycles; done_o follows the last issue by one cycle.
- Address and counter never wrap. The counter width holds NUM_AXONS-1; compare against NUM_AXONS-1, never rely on overflow.
- At most one of start_o, rdEn_RclInSpike_o, saveRclSpikes_o, rdEn_LrnInSpike_o is high in any cycle.
- tick_i while busy_o=1 is ignored and sets overrun_o. tick_i in the same cycle that DONE returns to IDLE also counts as busy.
- lrn_en_i changes mid-timestep have no effect until the next accepted tick.
- rcl_vld_o/lrn_vld_o and the axon/last strobes are pipeline copies of the issue signals, one cycle later. They continue correctly across a state change (the last recall valid appears during SAVE or DONE).

Decomposition:
- Shared package (neuron defines): state encoding constants (IDLE..DONE, 3 bits) and the default AXON_CNT_BIT_WIDTH.
- One natural sub-module: axon_sweep_cnt, a counter with enable, terminal-count flag and clear.
  - Instantiated once and shared by RCL and LRN, since the phases are mutually exclusive.

Test Plan:
- NUM_AXONS=8, rdy_i=1, lrn_en_i=0, tick at cycle 0:
  - start_o at 1; recall addrs 0..7 issued at cycles 2..9; rcl_vld_o at 3..10 with rcl_last_o at 10.
  - done_o at 10; no saveRclSpikes_o or learn reads.
- Same setup with lrn_en_i=1:
  - saveRclSpikes_o at 10; learn addrs 0..7 at 11..18; lrn_vld_o at 12..19; done_o at 19.
- rdy_i low during cycles 4–6 of recall:
  - Address holds at 2 for three cycles with no rdEn; the sweep completes with exactly 8 issues and no skipped or duplicated address.
- Second tick at cycle 5 (busy):
  - Ignored; overrun_o goes high and stays high.
  - Next tick after done_o is accepted normally and overrun_o remains 1.
- rst_i asserted at cycle 6 mid-recall:
  - All outputs 0 and busy_o=0 on the next cycle; a fresh tick restarts at address 0.
- lrn_en_i toggles to 1 during a recall sweep that started with lrn_en_i=0:
  - No SAVE/LRN in this timestep; the next tick with lrn_en_i=1 runs the learn phase.
